i2c_burst_sequencer: RTL and testbench
======================================

// Module: i2c_burst_sequencer
// PURPOSE
//  Parametrised I2C transaction sequencer; drives the byte-level i2c_controller command interface.
//  Optional bus scan, one configuration-register write, then N-byte burst reads (e.g. MPU gyro+accel), one-shot or periodic.
//  Sits between top-level control and i2c_controller; presents a coherent sample frame plus status.
// PARAMETERS
//  DEV_ADDR      7'h68  target 7-bit address used when SCAN_EN=0
//  SCAN_EN       1      1: probe 0x00..0x7F, use first ACKing address; 0: use DEV_ADDR
//  CFG_REG       8'h6B  configuration register address
//  CFG_VAL       8'h00  value written to CFG_REG
//  DATA_REG      8'h43  first data register of burst
//  NUM_BYTES     12     bytes per burst (1..64)
//  POLL_CYCLES   100000 clk cycles between bursts in continuous mode (>=1)
//  MAX_RETRIES   3      NACK retries per phase before ERROR
// PORTS
//  clk             in   1             system clock
//  reset           in   1             synchronous, active-high
//  start           in   1             level; begins sequence from IDLE/DONE/ERROR
//  continuous      in   1             1: repeat bursts every POLL_CYCLES; sampled at each burst end
//  controller_idle in   1             i2c_controller ready for a command
//  ack_received    in   1             valid when controller_idle returns high
//  nack_received   in   1             valid when controller_idle returns high
//  data_out        in   8             read byte, valid when idle returns after read_enable
//  device_addr     out  7             target address
//  R_Wbar          out  1             1 read, 0 write; held with send_start
//  send_start      out  1             1-cycle pulse (START or repeated START + address)
//  data_in         out  8             byte to write; held with write_enable
//  write_enable    out  1             1-cycle pulse
//  read_enable     out  1             1-cycle pulse
//  send_ack/send_nack/send_stop out 1 each  1-cycle pulses
//  samples         out  8*NUM_BYTES   last complete frame; byte0 (DATA_REG) in MSBs
//  sample_valid    out  1             1-cycle pulse when samples updated
//  sample_count    out  16            frames completed, wraps 0xFFFF->0
//  found_addr      out  7             address in use
//  busy/done/error out  1 each        status levels
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, retry/byte/poll counters 0; reset mid-transfer abandons bus (no STOP).
//  Command rule: each pulse issued only in a cycle with controller_idle=1; next state is WAIT, which ignores
//   idle for 1 cycle then waits idle=1; then ack/nack/data_out sampled. Never two pulses without an intervening WAIT.
//  States: IDLE, SCAN, CFG_ADDR, CFG_REG, CFG_VAL, RD_ADDR, RD_REG, RD_RSTART, RD_BYTE, RD_ACK, STOP, POLL, DONE, ERROR.
//  IDLE/DONE/ERROR + start -> SCAN (SCAN_EN) else CFG_ADDR; clears error/done, retries; busy=1 outside these three.
//  SCAN: START(addr,W); ACK -> found_addr=addr, STOP, CFG_ADDR; NACK -> STOP, addr+1; NACK at 0x7F -> ERROR.
//  CFG: START(dev,W), write CFG_REG, write CFG_VAL, STOP -> RD_ADDR.
//  RD: START(dev,W), write DATA_REG, repeated START(dev,R) (no STOP), then per byte read_enable, store,
//   send_ack for bytes 0..N-2, send_nack for byte N-1, STOP.
//  Bytes collect in shadow buffer; after final STOP completes, samples<=shadow, sample_valid=1, sample_count+1 same cycle.
//  After burst: continuous=1 -> POLL counts POLL_CYCLES then RD_ADDR; else DONE (done=1).
//  Any NACK in CFG/RD phase: STOP, retry++ and restart that phase (CFG_ADDR or RD_ADDR); retry>MAX_RETRIES -> ERROR.
//   Retry counter clears on a successful phase. samples unchanged on failed burst.
//  ack and nack both high: treated as NACK. start held high in DONE/ERROR restarts immediately.
//  ERROR: error=1, bus left after STOP, held until start or reset.
// TESTING (BFM i2c_controller, idle low 20 cycles per command)
//  SCAN_EN=1, BFM ACKs only 0x68 -> 0x69 probes, found_addr=0x68, CFG writes 0x6B,0x00, first burst follows.
//  NUM_BYTES=12, BFM returns 0x01..0x0C -> samples=96'h0102..0C, 11 send_ack + 1 send_nack, one sample_valid.
//  continuous=1, POLL_CYCLES=50 -> 3 frames, sample_count=3, burst starts spaced >=50 cycles; drop continuous -> DONE.
//  NACK on DATA_REG write 4 times, MAX_RETRIES=3 -> 4 STOPs, error=1, samples unchanged; start -> recovers.
//  SCAN_EN=1, no device ACKs -> 128 probes, ERROR, found_addr=0.
//  reset asserted mid-RD_BYTE -> next cycle all outputs 0, state IDLE, no pulses until start.

Source files
------------

// File: rtl/i2c_burst_sequencer_if.sv
// Byte-level command/response bus between the burst sequencer (master) and an
// i2c_controller (slave).
interface i2c_burst_sequencer_if;
  logic [6:0] device_addr;
  logic       R_Wbar;
  logic       send_start;
  logic [7:0] data_in;
  logic       write_enable;
  logic       read_enable;
  logic       send_ack;
  logic       send_nack;
  logic       send_stop;
  logic       controller_idle;
  logic       ack_received;
  logic       nack_received;
  logic [7:0] data_out;

  modport master (
    output device_addr, R_Wbar, send_start, data_in, write_enable, read_enable,
           send_ack, send_nack, send_stop,
    input  controller_idle, ack_received, nack_received, data_out
  );

  modport slave (
    input  device_addr, R_Wbar, send_start, data_in, write_enable, read_enable,
           send_ack, send_nack, send_stop,
    output controller_idle, ack_received, nack_received, data_out
  );
endinterface

// File: rtl/i2c_burst_sequencer.sv
// Finds (or assumes) an I2C device, writes one configuration register, then runs
// N-byte burst reads through a byte-level i2c_controller, one-shot or periodic.
module i2c_burst_sequencer #(
  parameter logic [6:0] DEV_ADDR    = 7'h68,
  parameter bit         SCAN_EN     = 1'b1,
  parameter logic [7:0] CFG_REG     = 8'h6B,
  parameter logic [7:0] CFG_VAL     = 8'h00,
  parameter logic [7:0] DATA_REG    = 8'h43,
  parameter int         NUM_BYTES   = 12,
  parameter int         POLL_CYCLES = 100000,
  parameter int         MAX_RETRIES = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     continuous,
  i2c_burst_sequencer_if.master    bus,
  output logic [8*NUM_BYTES-1:0]   samples,
  output logic                     sample_valid,
  output logic [15:0]              sample_count,
  output logic [6:0]               found_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  typedef enum logic [3:0] {
    S_IDLE, S_SCAN, S_CFG_ADDR, S_CFG_REG, S_CFG_VAL, S_RD_ADDR, S_RD_REG,
    S_RD_RSTART, S_RD_BYTE, S_RD_ACK, S_STOP, S_POLL, S_DONE, S_ERROR, S_WAIT
  } state_t;

  localparam int          FW          = 8 * NUM_BYTES;
  localparam logic [6:0]  LAST_BYTE   = 7'(NUM_BYTES - 1);
  localparam logic [31:0] POLL_LAST   = 32'(POLL_CYCLES - 1);
  localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRIES);

  state_t        state_r, state_n, ret_r, ret_n, after_r, after_n, restart_s;
  logic          commit_r, commit_n, skip_r, skip_n;
  logic [6:0]    scan_addr_r, scan_addr_n, byte_idx_r, byte_idx_n;
  logic [6:0]    found_addr_r, found_addr_n, dev_addr_r, dev_addr_n;
  logic [7:0]    retry_r, retry_n, data_in_r, data_in_n;
  logic [31:0]   poll_cnt_r, poll_cnt_n;
  logic [FW-1:0] shadow_r, shadow_n, samples_r, samples_n;
  logic [15:0]   sample_count_r, sample_count_n;
  logic          sample_valid_r, sample_valid_n, busy_r, busy_n;
  logic          done_r, done_n, error_r, error_n;
  logic          rw_r, rw_n, start_r, start_n, write_r, write_n, read_r, read_n;
  logic          ack_r, ack_n, nack_r, nack_n, stop_r, stop_n;
  logic          issue_s, fail_s, resp_ok_s, last_byte_s;

  // Simultaneous ack and nack counts as a NACK.
  assign resp_ok_s   = bus.ack_received & ~bus.nack_received;
  assign last_byte_s = (byte_idx_r == LAST_BYTE);

  // Next-state, command and status decode; every command leads into WAIT.
  always_comb begin
    state_n        = state_r;
    ret_n          = ret_r;
    after_n        = after_r;
    restart_s      = S_CFG_ADDR;
    commit_n       = commit_r;
    skip_n         = 1'b0;
    scan_addr_n    = scan_addr_r;
    byte_idx_n     = byte_idx_r;
    found_addr_n   = found_addr_r;
    dev_addr_n     = dev_addr_r;
    retry_n        = retry_r;
    data_in_n      = data_in_r;
    poll_cnt_n     = poll_cnt_r;
    shadow_n       = shadow_r;
    samples_n      = samples_r;
    sample_count_n = sample_count_r;
    sample_valid_n = 1'b0;
    rw_n           = rw_r;
    start_n        = 1'b0;
    write_n        = 1'b0;
    read_n         = 1'b0;
    ack_n          = 1'b0;
    nack_n         = 1'b0;
    stop_n         = 1'b0;
    issue_s        = 1'b0;
    fail_s         = 1'b0;

    case (state_r)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          retry_n  = 8'd0;
          commit_n = 1'b0;
          if (SCAN_EN) begin
            state_n      = S_SCAN;
            scan_addr_n  = 7'd0;
            found_addr_n = 7'd0;
          end else begin
            state_n      = S_CFG_ADDR;
            found_addr_n = DEV_ADDR;
          end
        end else begin
          state_n = state_r;
        end
      end
      S_SCAN:      begin issue_s = bus.controller_idle; start_n = issue_s; dev_addr_n = scan_addr_r;  rw_n = 1'b0; end
      S_CFG_ADDR:  begin issue_s = bus.controller_idle; start_n = issue_s; dev_addr_n = found_addr_r; rw_n = 1'b0; end
      S_RD_ADDR:   begin issue_s = bus.controller_idle; start_n = issue_s; dev_addr_n = found_addr_r; rw_n = 1'b0; end
      S_RD_RSTART: begin issue_s = bus.controller_idle; start_n = issue_s; dev_addr_n = found_addr_r; rw_n = 1'b1; end
      S_CFG_REG:   begin issue_s = bus.controller_idle; write_n = issue_s; data_in_n = CFG_REG;  end
      S_CFG_VAL:   begin issue_s = bus.controller_idle; write_n = issue_s; data_in_n = CFG_VAL;  end
      S_RD_REG:    begin issue_s = bus.controller_idle; write_n = issue_s; data_in_n = DATA_REG; end
      S_RD_BYTE:   begin issue_s = bus.controller_idle; read_n  = issue_s; end
      S_RD_ACK: begin
        issue_s = bus.controller_idle;
        ack_n   = issue_s & ~last_byte_s;
        nack_n  = issue_s & last_byte_s;
      end
      S_STOP:      begin issue_s = bus.controller_idle; stop_n = issue_s; end
      S_POLL: begin
        if (poll_cnt_r == POLL_LAST) begin
          state_n = S_RD_ADDR;
        end else begin
          poll_cnt_n = poll_cnt_r + 32'd1;
        end
      end
      S_WAIT: begin
        // The controller may still show idle in the cycle right after a pulse.
        if (skip_r || !bus.controller_idle) begin
          state_n = S_WAIT;
        end else begin
          case (ret_r)
            S_SCAN: begin
              state_n = S_STOP;
              if (resp_ok_s) begin
                found_addr_n = scan_addr_r;
                after_n      = S_CFG_ADDR;
              end else if (scan_addr_r == 7'h7F) begin
                after_n = S_ERROR;
              end else begin
                scan_addr_n = scan_addr_r + 7'd1;
                after_n     = S_SCAN;
              end
            end
            S_CFG_ADDR: begin fail_s = ~resp_ok_s; state_n = S_CFG_REG; end
            S_CFG_REG:  begin fail_s = ~resp_ok_s; state_n = S_CFG_VAL; end
            S_CFG_VAL: begin
              fail_s  = ~resp_ok_s;
              state_n = S_STOP;
              after_n = S_RD_ADDR;
              retry_n = 8'd0;
            end
            S_RD_ADDR: begin fail_s = ~resp_ok_s; restart_s = S_RD_ADDR; state_n = S_RD_REG; end
            S_RD_REG:  begin fail_s = ~resp_ok_s; restart_s = S_RD_ADDR; state_n = S_RD_RSTART; end
            S_RD_RSTART: begin
              fail_s     = ~resp_ok_s;
              restart_s  = S_RD_ADDR;
              state_n    = S_RD_BYTE;
              byte_idx_n = 7'd0;
            end
            S_RD_BYTE: begin
              for (int i = 0; i < NUM_BYTES; i++) begin
                if (byte_idx_r == 7'(i)) begin
                  shadow_n[8*(NUM_BYTES-1-i) +: 8] = bus.data_out;
                end else begin
                  shadow_n[8*(NUM_BYTES-1-i) +: 8] = shadow_r[8*(NUM_BYTES-1-i) +: 8];
                end
              end
              state_n = S_RD_ACK;
            end
            S_RD_ACK: begin
              if (last_byte_s) begin
                state_n  = S_STOP;
                commit_n = 1'b1;
              end else begin
                byte_idx_n = byte_idx_r + 7'd1;
                state_n    = S_RD_BYTE;
              end
            end
            S_STOP: begin
              if (commit_r) begin
                samples_n      = shadow_r;
                sample_valid_n = 1'b1;
                sample_count_n = sample_count_r + 16'd1;
                retry_n        = 8'd0;
                commit_n       = 1'b0;
                poll_cnt_n     = 32'd0;
                state_n        = continuous ? S_POLL : S_DONE;
              end else begin
                state_n = after_r;
              end
            end
            default: state_n = S_IDLE;
          endcase
          // A NACK abandons the phase: STOP, then retry it or give up.
          if (fail_s) begin
            state_n  = S_STOP;
            commit_n = 1'b0;
            if (retry_r >= RETRY_LIMIT) begin
              after_n = S_ERROR;
            end else begin
              retry_n = retry_r + 8'd1;
              after_n = restart_s;
            end
          end else begin
            retry_n = retry_n;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (issue_s) begin
      ret_n   = state_r;
      state_n = S_WAIT;
      skip_n  = 1'b1;
    end else begin
      ret_n = ret_r;
    end

    busy_n  = !(state_n inside {S_IDLE, S_DONE, S_ERROR});
    done_n  = (state_n == S_DONE);
    error_n = (state_n == S_ERROR);
  end

  // State and output registers; reset abandons any bus transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= S_IDLE;
      ret_r          <= S_IDLE;
      after_r        <= S_IDLE;
      commit_r       <= 1'b0;
      skip_r         <= 1'b0;
      scan_addr_r    <= 7'd0;
      byte_idx_r     <= 7'd0;
      found_addr_r   <= 7'd0;
      dev_addr_r     <= 7'd0;
      retry_r        <= 8'd0;
      data_in_r      <= 8'd0;
      poll_cnt_r     <= 32'd0;
      shadow_r       <= '0;
      samples_r      <= '0;
      sample_count_r <= 16'd0;
      sample_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      rw_r           <= 1'b0;
      start_r        <= 1'b0;
      write_r        <= 1'b0;
      read_r         <= 1'b0;
      ack_r          <= 1'b0;
      nack_r         <= 1'b0;
      stop_r         <= 1'b0;
    end else begin
      state_r        <= state_n;
      ret_r          <= ret_n;
      after_r        <= after_n;
      commit_r       <= commit_n;
      skip_r         <= skip_n;
      scan_addr_r    <= scan_addr_n;
      byte_idx_r     <= byte_idx_n;
      found_addr_r   <= found_addr_n;
      dev_addr_r     <= dev_addr_n;
      retry_r        <= retry_n;
      data_in_r      <= data_in_n;
      poll_cnt_r     <= poll_cnt_n;
      shadow_r       <= shadow_n;
      samples_r      <= samples_n;
      sample_count_r <= sample_count_n;
      sample_valid_r <= sample_valid_n;
      busy_r         <= busy_n;
      done_r         <= done_n;
      error_r        <= error_n;
      rw_r           <= rw_n;
      start_r        <= start_n;
      write_r        <= write_n;
      read_r         <= read_n;
      ack_r          <= ack_n;
      nack_r         <= nack_n;
      stop_r         <= stop_n;
    end
  end

  assign bus.device_addr  = dev_addr_r;
  assign bus.R_Wbar       = rw_r;
  assign bus.send_start   = start_r;
  assign bus.data_in      = data_in_r;
  assign bus.write_enable = write_r;
  assign bus.read_enable  = read_r;
  assign bus.send_ack     = ack_r;
  assign bus.send_nack    = nack_r;
  assign bus.send_stop    = stop_r;
  assign samples          = samples_r;
  assign sample_valid     = sample_valid_r;
  assign sample_count     = sample_count_r;
  assign found_addr       = found_addr_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign error            = error_r;

endmodule

// File: tb/tb_i2c_burst_sequencer.sv
// Bench for i2c_burst_sequencer: a 20-cycle controller model answers commands and
// a frame scoreboard checks every sample_valid against bench-computed frames.
module tb_i2c_burst_sequencer;
  localparam int NB   = 12;
  localparam int POLL = 50;

  logic clk = 1'b0;
  logic reset, start, continuous;
  logic [8*NB-1:0] samples;
  logic sample_valid, busy, done, error;
  logic [15:0] sample_count;
  logic [6:0] found_addr;

  i2c_burst_sequencer_if bus();

  i2c_burst_sequencer #(.NUM_BYTES(NB), .POLL_CYCLES(POLL)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .bus(bus),
    .samples(samples), .sample_valid(sample_valid), .sample_count(sample_count),
    .found_addr(found_addr), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8*NB-1:0] frame_of(input logic [7:0] base);
    logic [8*NB-1:0] f;
    for (int i = 0; i < NB; i++) f[8*(NB-1-i) +: 8] = base + 8'(i + 1);
    return f;
  endfunction

  // Controller model state and statistics
  int cyc = 0;
  bit ack_en = 1'b1;
  int inject_nacks = 0;
  int burst_no = 0, read_idx = 0;
  logic [7:0] cur_base = 8'd0;
  int probe_nacks = 0, starts_seen = 0, stops_after_rd = 0;
  int acks_sent = 0, nacks_sent = 0, proto_err = 0;
  bit rd_seen = 1'b0;
  logic [7:0] writes[$];
  int gaps[$];
  bit gap_armed = 1'b0;
  int sv_cyc = 0;
  int sv_seen = 0;
  logic [8*NB-1:0] exp_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Controller model: takes one command while idle, answers 20 cycles later.
  initial begin
    int bfm_busy;
    int cmds;
    logic rsp_ok;
    logic [7:0] rsp_data;
    bfm_busy = 0;
    rsp_ok = 1'b0;
    rsp_data = 8'd0;
    forever begin
      @(negedge clk);
      cmds = int'(bus.send_start) + int'(bus.write_enable) + int'(bus.read_enable)
           + int'(bus.send_ack) + int'(bus.send_nack) + int'(bus.send_stop);
      if (reset) begin
        bfm_busy = 0;
        bus.controller_idle = 1'b1;
        bus.ack_received = 1'b0;
        bus.nack_received = 1'b0;
        bus.data_out = 8'd0;
      end else if (bfm_busy > 0) begin
        if (cmds != 0) proto_err++;
        bfm_busy--;
        if (bfm_busy == 0) begin
          bus.controller_idle = 1'b1;
          bus.ack_received = rsp_ok;
          bus.nack_received = ~rsp_ok;
          bus.data_out = rsp_data;
        end
      end else if (cmds > 1) begin
        proto_err++;
      end else if (cmds == 1) begin
        rsp_ok = 1'b1;
        if (bus.send_start) begin
          starts_seen++;
          rsp_ok = ack_en && (bus.device_addr == 7'h68);
          if (!rsp_ok && !bus.R_Wbar) probe_nacks++;
          if (bus.R_Wbar) begin
            cur_base = 8'(burst_no * 16);
            burst_no++;
            read_idx = 0;
          end
          if (gap_armed) begin
            gaps.push_back(cyc - sv_cyc);
            gap_armed = 1'b0;
          end
        end else if (bus.write_enable) begin
          writes.push_back(bus.data_in);
          if (bus.data_in == 8'h43) begin
            rd_seen = 1'b1;
            if (inject_nacks > 0) begin
              rsp_ok = 1'b0;
              inject_nacks--;
            end
          end
        end else if (bus.read_enable) begin
          rsp_data = cur_base + 8'(read_idx + 1);
          read_idx++;
        end else if (bus.send_ack) begin
          acks_sent++;
        end else if (bus.send_nack) begin
          nacks_sent++;
        end else if (bus.send_stop && rd_seen) begin
          stops_after_rd++;
        end
        bus.controller_idle = 1'b0;
        bfm_busy = 20;
      end
    end
  end

  // Scoreboard: each completed frame must match the oldest expected frame.
  initial begin
    int exp_count;
    exp_count = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_count = 0;
      end else if (sample_valid) begin
        sv_seen++;
        exp_count++;
        sv_cyc = cyc;
        gap_armed = 1'b1;
        if (exp_q.size() == 0) check_val("unexpected_frame", 1, 0);
        else check_val("frame", samples, exp_q.pop_front());
        check_val("sample_count", sample_count, exp_count);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(done || error) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) check_val(tag, 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_frames(input int base, input int count, input string tag);
    int n = 0;
    while ((sv_seen - base) < count && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) check_val(tag, 0, 1);
  endtask

  initial begin
    int sv_base;
    int n;
    int pulses_seen;
    reset = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_status", {busy, done, error, sample_valid}, 4'b0000);
    check_val("rst_samples", samples, '0);
    check_val("rst_count_addr", {sample_count, found_addr}, '0);
    check_val("rst_bus", {bus.send_start, bus.write_enable, bus.read_enable, bus.send_ack,
              bus.send_nack, bus.send_stop, bus.device_addr, bus.R_Wbar, bus.data_in}, '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Scan, configure, single burst
    writes.delete();
    sv_base = sv_seen;
    exp_q.push_back(frame_of(8'h00));
    pulse_start();
    wait_end("A_timeout");
    check_val("A_done_error", {done, error}, 2'b10);
    check_val("A_probe_nacks", probe_nacks, 32'd104);  // addresses 0x00..0x67
    check_val("A_found_addr", found_addr, 7'h68);
    check_val("A_write_count", writes.size(), 32'd3);
    check_val("A_wr_cfg_reg", writes[0], 8'h6B);
    check_val("A_wr_cfg_val", writes[1], 8'h00);
    check_val("A_wr_data_reg", writes[2], 8'h43);
    check_val("A_send_acks", acks_sent, 32'd11);
    check_val("A_send_nacks", nacks_sent, 32'd1);
    check_val("A_frames", sv_seen - sv_base, 32'd1);
    check_val("A_sample_count", sample_count, 16'd1);

    // Continuous: three frames spaced by the poll interval
    continuous = 1'b1;
    gaps.delete();
    gap_armed = 1'b0;
    sv_base = sv_seen;
    exp_q.push_back(frame_of(8'h10));
    exp_q.push_back(frame_of(8'h20));
    exp_q.push_back(frame_of(8'h30));
    pulse_start();
    wait_frames(sv_base, 2, "B_frames_timeout");
    continuous = 1'b0;
    wait_end("B_timeout");
    check_val("B_done_error", {done, error}, 2'b10);
    check_val("B_frames", sv_seen - sv_base, 32'd3);
    check_val("B_sample_count", sample_count, 16'd4);
    check_val("B_gap_count_ok", gaps.size() >= 2, 1'b1);
    for (int i = 0; i < 2 && i < gaps.size(); i++)
      check_val("B_poll_gap_ok", (gaps[i] >= POLL) && (gaps[i] <= POLL + 4), 1'b1);

    // DATA_REG write NACKed four times
    inject_nacks = 4;
    rd_seen = 1'b0;
    stops_after_rd = 0;
    sv_base = sv_seen;
    pulse_start();
    wait_end("C_timeout");
    check_val("C_done_error", {done, error}, 2'b01);
    check_val("C_retry_stops", stops_after_rd, 32'd4);
    check_val("C_frames", sv_seen - sv_base, 32'd0);
    check_val("C_samples_kept", samples, frame_of(8'h30));
    check_val("C_busy", busy, 1'b0);
    exp_q.push_back(frame_of(8'h40));
    pulse_start();
    wait_end("C_recover_timeout");
    check_val("C_recover_done_error", {done, error}, 2'b10);
    check_val("C_recover_count", sample_count, 16'd5);

    // No device answers the scan
    ack_en = 1'b0;
    starts_seen = 0;
    sv_base = sv_seen;
    pulse_start();
    wait_end("D_timeout");
    check_val("D_done_error", {done, error}, 2'b01);
    check_val("D_probes", starts_seen, 32'd128);
    check_val("D_found_addr", found_addr, 7'h00);
    check_val("D_samples_kept", samples, frame_of(8'h40));
    ack_en = 1'b1;

    // Reset during a burst read
    pulse_start();
    n = 0;
    while (!bus.read_enable && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) check_val("E_read_timeout", 0, 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("E_rst_status", {busy, done, error, sample_valid, sample_count, found_addr}, '0);
    check_val("E_rst_samples", samples, '0);
    check_val("E_rst_bus", {bus.send_start, bus.write_enable, bus.read_enable, bus.send_ack,
              bus.send_nack, bus.send_stop, bus.device_addr, bus.R_Wbar, bus.data_in}, '0);
    reset = 1'b0;
    pulses_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.send_start || bus.write_enable || bus.read_enable || bus.send_ack ||
          bus.send_nack || bus.send_stop) pulses_seen++;
    end
    check_val("E_quiet", pulses_seen, 32'd0);
    check_val("E_idle_status", {busy, done, error}, 3'b000);

    check_val("protocol_errors", proto_err, 32'd0);
    check_val("frames_outstanding", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
